// File: rtl/minesweeper_pkg.sv
// ============================================================================
// Package     : minesweeper_pkg
// Description : Shared board geometry, sequencer state encoding and the
//               neighbour offset table for the number-board update logic.
//               Optional macro ADJ_CLEAR_EN adds the CLEAR state (widens the
//               one-hot state vector from 5 to 6 bits).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package minesweeper_pkg;

    localparam int BOARD_W = 16;
    localparam int BOARD_H = 16;
    localparam int XW      = 4;
    localparam int YW      = 4;
    localparam int CW      = 4;
    localparam int AW      = 8;

    // One-hot sequencer states
`ifdef ADJ_CLEAR_EN
    localparam int ST_W = 6;
`else
    localparam int ST_W = 5;
`endif
    localparam logic [ST_W-1:0] ST_IDLE  = ST_W'(1);
    localparam logic [ST_W-1:0] ST_CHECK = ST_W'(2);
    localparam logic [ST_W-1:0] ST_WAIT  = ST_W'(4);
    localparam logic [ST_W-1:0] ST_WRITE = ST_W'(8);
    localparam logic [ST_W-1:0] ST_DONE  = ST_W'(16);
`ifdef ADJ_CLEAR_EN
    localparam logic [ST_W-1:0] ST_CLEAR = ST_W'(32);
`endif

    // Neighbour walk order, k = 0..7:
    //   (-1,-1) (0,-1) (+1,-1) (-1,0) (+1,0) (-1,+1) (0,+1) (+1,+1)
    function automatic logic signed [1:0] nb_dx(input logic [2:0] k);
        case (k)
            3'd0, 3'd3, 3'd5: nb_dx = -2'sd1;
            3'd1, 3'd6:       nb_dx = 2'sd0;
            default:          nb_dx = 2'sd1;
        endcase
    endfunction

    function automatic logic signed [1:0] nb_dy(input logic [2:0] k);
        case (k)
            3'd0, 3'd1, 3'd2: nb_dy = -2'sd1;
            3'd3, 3'd4:       nb_dy = 2'sd0;
            default:          nb_dy = 2'sd1;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/adj_neighbor_gen.sv
// ============================================================================
// Module      : adj_neighbor_gen
// Description : Combinational neighbour generator. Maps mine position (x,y)
//               and neighbour index k to the neighbour coordinates, an
//               in-bounds flag and the linear RAM address y*BOARD_W + x.
// Ports       : x, y       - mine coordinates
//               k          - neighbour index 0..7
//               nx, ny     - signed neighbour coordinates (may be -1 or W/H)
//               in_bounds  - neighbour lies on the board
//               addr       - RAM address of the neighbour (valid if in_bounds)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module adj_neighbor_gen #(
    parameter int BOARD_W = minesweeper_pkg::BOARD_W,
    parameter int BOARD_H = minesweeper_pkg::BOARD_H,
    parameter int XW      = minesweeper_pkg::XW,
    parameter int YW      = minesweeper_pkg::YW,
    parameter int AW      = minesweeper_pkg::AW
) (
    input  logic [XW-1:0]        x,
    input  logic [YW-1:0]        y,
    input  logic [2:0]           k,
    output logic signed [XW+1:0] nx,
    output logic signed [YW+1:0] ny,
    output logic                 in_bounds,
    output logic [AW-1:0]        addr
);
    import minesweeper_pkg::*;

    // Two extra bits: one for the sign (x-1 at column 0), one for x+1 == 2^XW
    localparam logic signed [XW+1:0] c_x_lim = (XW+2)'(BOARD_W);
    localparam logic signed [YW+1:0] c_y_lim = (YW+2)'(BOARD_H);

    logic signed [1:0] dx;
    logic signed [1:0] dy;

    always_comb begin
        dx        = nb_dx(k);
        dy        = nb_dy(k);
        nx        = $signed({2'b00, x} + {{XW{dx[1]}}, dx});
        ny        = $signed({2'b00, y} + {{YW{dy[1]}}, dy});
        in_bounds = !nx[XW+1] && (nx < c_x_lim) && !ny[YW+1] && (ny < c_y_lim);
        addr      = AW'(ny[YW-1:0]) * AW'(BOARD_W) + AW'(nx[XW-1:0]);
    end

endmodule

`default_nettype wire

// File: rtl/adj_count_sequencer.sv
// ============================================================================
// Module      : adj_count_sequencer
// Description : After a mine is placed, read-modify-writes the adjacency
//               count of each in-bounds neighbour in the number-board RAM
//               (saturating increment). Owns the single RAM port and shares
//               it with the display scanner: the display is granted at most
//               once per in-bounds neighbour while busy, so it never waits
//               longer than one read-modify-write.
// Ports       : clk, reset (async, active-high)
//               start, x_in, y_in       - update request from mine placer
//               busy, done              - progress / completion pulse
//               ram_addr, ram_we, ram_wdata, ram_rdata - number-board RAM
//               disp_req, disp_addr, disp_gnt, disp_rvalid - display port
//               clear                   - board clear (only with ADJ_CLEAR_EN)
// Options     : `define ADJ_CLEAR_EN enables the CLEAR state, which writes 0
//               to every cell; otherwise clear is ignored.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module adj_count_sequencer #(
    parameter int BOARD_W = minesweeper_pkg::BOARD_W,
    parameter int BOARD_H = minesweeper_pkg::BOARD_H,
    parameter int XW      = minesweeper_pkg::XW,
    parameter int YW      = minesweeper_pkg::YW,
    parameter int CW      = minesweeper_pkg::CW,
    parameter int AW      = minesweeper_pkg::AW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [XW-1:0] x_in,
    input  logic [YW-1:0] y_in,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] ram_addr,
    output logic          ram_we,
    output logic [CW-1:0] ram_wdata,
    input  logic [CW-1:0] ram_rdata,
    input  logic          disp_req,
    input  logic [AW-1:0] disp_addr,
    output logic          disp_gnt,
    output logic          disp_rvalid,
    input  logic          clear
);
    import minesweeper_pkg::*;

    localparam logic [CW-1:0] c_cnt_max = '1;
`ifdef ADJ_CLEAR_EN
    localparam logic [AW-1:0] c_last_cell = AW'(BOARD_W * BOARD_H - 1);
`endif

    logic [ST_W-1:0] state_q, state_d;
    logic [2:0]      k_q, k_d;
    logic [XW-1:0]   x_q, x_d;
    logic [YW-1:0]   y_q, y_d;
    logic [CW-1:0]   inc_q, inc_d;
    logic            disp_served_q, disp_served_d;
    logic            disp_rvalid_q, disp_rvalid_d;
`ifdef ADJ_CLEAR_EN
    logic [AW-1:0]   clr_addr_q, clr_addr_d;
`endif

    logic signed [XW+1:0] nb_x;
    logic signed [YW+1:0] nb_y;
    logic                 nb_in;
    logic [AW-1:0]        nb_addr;

    adj_neighbor_gen #(
        .BOARD_W (BOARD_W),
        .BOARD_H (BOARD_H),
        .XW      (XW),
        .YW      (YW),
        .AW      (AW)
    ) u_nb (
        .x         (x_q),
        .y         (y_q),
        .k         (k_q),
        .nx        (nb_x),
        .ny        (nb_y),
        .in_bounds (nb_in),
        .addr      (nb_addr)
    );

    // Coordinates are only needed for the in-bounds decision inside the
    // generator; clear is a don't-care when the clear feature is absent.
    logic unused_sinks;
`ifdef ADJ_CLEAR_EN
    assign unused_sinks = &{1'b0, nb_x, nb_y};
`else
    assign unused_sinks = &{1'b0, nb_x, nb_y, clear};
`endif

    always_comb begin
        state_d       = state_q;
        k_d           = k_q;
        x_d           = x_q;
        y_d           = y_q;
        inc_d         = inc_q;
        disp_served_d = disp_served_q;
`ifdef ADJ_CLEAR_EN
        clr_addr_d    = clr_addr_q;
`endif
        busy          = 1'b0;
        done          = 1'b0;
        disp_gnt      = 1'b0;
        ram_we        = 1'b0;
        ram_addr      = '0;
        ram_wdata     = '0;

        case (state_q)
            ST_IDLE: begin
                disp_gnt = disp_req;
                if (disp_req) begin
                    ram_addr = disp_addr;
                end
`ifdef ADJ_CLEAR_EN
                if (clear) begin
                    clr_addr_d = '0;
                    state_d    = ST_CLEAR;
                end else if (start) begin
`else
                if (start) begin
`endif
                    x_d           = x_in;
                    y_d           = y_in;
                    k_d           = 3'd0;
                    disp_served_d = 1'b0;
                    state_d       = ST_CHECK;
                end
            end

            ST_CHECK: begin
                busy = 1'b1;
                if (!nb_in) begin
                    if (k_q == 3'd7) begin
                        state_d = ST_DONE;
                    end else begin
                        k_d = k_q + 3'd1;
                    end
                end else if (disp_req && !disp_served_q) begin
                    // One display slot per in-bounds neighbour bounds the
                    // display's wait to a single read-modify-write.
                    disp_gnt      = 1'b1;
                    ram_addr      = disp_addr;
                    disp_served_d = 1'b1;
                end else begin
                    ram_addr      = nb_addr;
                    disp_served_d = 1'b0;
                    state_d       = ST_WAIT;
                end
            end

            ST_WAIT: begin
                busy     = 1'b1;
                ram_addr = nb_addr;
                inc_d    = (ram_rdata == c_cnt_max) ? c_cnt_max : ram_rdata + 1'b1;
                state_d  = ST_WRITE;
            end

            ST_WRITE: begin
                busy      = 1'b1;
                ram_we    = 1'b1;
                ram_addr  = nb_addr;
                ram_wdata = inc_q;
                if (k_q == 3'd7) begin
                    state_d = ST_DONE;
                end else begin
                    k_d     = k_q + 3'd1;
                    state_d = ST_CHECK;
                end
            end

            ST_DONE: begin
                done     = 1'b1;
                disp_gnt = disp_req;
                if (disp_req) begin
                    ram_addr = disp_addr;
                end
                state_d  = ST_IDLE;
            end

`ifdef ADJ_CLEAR_EN
            ST_CLEAR: begin
                busy      = 1'b1;
                ram_we    = 1'b1;
                ram_addr  = clr_addr_q;
                ram_wdata = '0;
                if (clr_addr_q == c_last_cell) begin
                    state_d = ST_DONE;
                end else begin
                    clr_addr_d = clr_addr_q + 1'b1;
                end
            end
`endif

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        disp_rvalid_d = disp_gnt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            k_q           <= 3'd0;
            x_q           <= '0;
            y_q           <= '0;
            inc_q         <= '0;
            disp_served_q <= 1'b0;
            disp_rvalid_q <= 1'b0;
`ifdef ADJ_CLEAR_EN
            clr_addr_q    <= '0;
`endif
        end else begin
            state_q       <= state_d;
            k_q           <= k_d;
            x_q           <= x_d;
            y_q           <= y_d;
            inc_q         <= inc_d;
            disp_served_q <= disp_served_d;
            disp_rvalid_q <= disp_rvalid_d;
`ifdef ADJ_CLEAR_EN
            clr_addr_q    <= clr_addr_d;
`endif
        end
    end

    assign disp_rvalid = disp_rvalid_q;

endmodule

`default_nettype wire
